// File: rtl/ws2812_frame_buffer.sv
// Double-buffered GRB frame store feeding a WS2812 serial driver over valid/ready.
// Define WS2812_FRAME_REFRESH_EN to re-stream the active frame until a new one is committed.
module ws2812_frame_buffer #(
    parameter int unsigned NUM_LEDS = 64,
    parameter int unsigned AW       = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_sof,
    output logic [23:0] px_data,
    output logic        px_valid,
    input  logic        px_ready,
    output logic        px_last,
    output logic        frame_err,
    output logic        busy
);

    localparam int unsigned  DEPTH     = 2 ** (AW + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_LEDS - 1);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_FILL = 2'd1;
    localparam logic [1:0] W_DONE = 2'd2;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_SEND = 1'b1;

`ifdef WS2812_FRAME_REFRESH_EN
    localparam bit REFRESH_EN = 1'b1;
`else
    localparam bit REFRESH_EN = 1'b0;
`endif

    logic [23:0]   mem [DEPTH];

    logic [1:0]    w_state, w_state_nxt;
    logic [1:0]    phase, phase_nxt;
    logic [AW-1:0] wr_addr, wr_addr_nxt;
    logic [7:0]    g_byte, g_nxt;
    logic [7:0]    r_byte, r_nxt;
    logic          err_nxt;
    logic          wr_en_c;

    logic [0:0]    r_state, r_state_nxt;
    logic [AW-1:0] rd_addr, rd_addr_nxt;
    logic          act, act_nxt;
    logic          valid_nxt, last_nxt;
    logic          rd_en_c;
    logic          last_acc_c;
    logic          swap_c;

    assign last_acc_c = px_valid && px_ready && px_last;
    // Swap needs a complete frame and a free reader (or, with refresh, the reader at its frame end).
    assign swap_c = (w_state == W_DONE) &&
                    ((r_state == R_IDLE) || (REFRESH_EN && last_acc_c));

    // Pixel RAM: the write bank is always the one the reader is not using.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[{~act, wr_addr}] <= {g_byte, r_byte, in_byte};
        end
    end

    // Registered RAM read doubles as the output pixel register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_data <= 24'h0;
        end else if (rd_en_c) begin
            px_data <= mem[{act, rd_addr}];
        end
    end

    // Write-side state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state   <= W_IDLE;
            phase     <= 2'd0;
            wr_addr   <= '0;
            g_byte    <= 8'h0;
            r_byte    <= 8'h0;
            frame_err <= 1'b0;
        end else begin
            w_state   <= w_state_nxt;
            phase     <= phase_nxt;
            wr_addr   <= wr_addr_nxt;
            g_byte    <= g_nxt;
            r_byte    <= r_nxt;
            frame_err <= err_nxt;
        end
    end

    // Byte assembly: G, R, then B commits the pixel.
    always_comb begin
        w_state_nxt = w_state;
        phase_nxt   = phase;
        wr_addr_nxt = wr_addr;
        g_nxt       = g_byte;
        r_nxt       = r_byte;
        err_nxt     = 1'b0;
        wr_en_c     = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (in_valid && in_sof) begin
                    g_nxt       = in_byte;
                    phase_nxt   = 2'd1;
                    wr_addr_nxt = '0;
                    w_state_nxt = W_FILL;
                end
            end
            W_FILL: begin
                if (in_valid && in_sof) begin
                    err_nxt     = 1'b1;
                    g_nxt       = in_byte;
                    phase_nxt   = 2'd1;
                    wr_addr_nxt = '0;
                end else if (in_valid) begin
                    case (phase)
                        2'd0: begin
                            g_nxt     = in_byte;
                            phase_nxt = 2'd1;
                        end
                        2'd1: begin
                            r_nxt     = in_byte;
                            phase_nxt = 2'd2;
                        end
                        default: begin
                            wr_en_c   = 1'b1;
                            phase_nxt = 2'd0;
                            if (wr_addr == LAST_ADDR) begin
                                wr_addr_nxt = '0;
                                w_state_nxt = W_DONE;
                            end else begin
                                wr_addr_nxt = wr_addr + AW'(1);
                            end
                        end
                    endcase
                end
            end
            W_DONE: begin
                if (in_valid) begin
                    err_nxt = 1'b1;
                end
                if (swap_c) begin
                    w_state_nxt = W_IDLE;
                end
            end
            default: begin
                w_state_nxt = W_IDLE;
            end
        endcase
    end

    // Read-side state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= R_IDLE;
            rd_addr  <= '0;
            act      <= 1'b0;
            px_valid <= 1'b0;
            px_last  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            r_state  <= r_state_nxt;
            rd_addr  <= rd_addr_nxt;
            act      <= act_nxt;
            px_valid <= valid_nxt;
            px_last  <= last_nxt;
            busy     <= (r_state_nxt == R_SEND);
        end
    end

    // Streaming: fetch when no pixel is presented, advance on acceptance.
    always_comb begin
        r_state_nxt = r_state;
        rd_addr_nxt = rd_addr;
        act_nxt     = act;
        valid_nxt   = px_valid;
        last_nxt    = px_last;
        rd_en_c     = 1'b0;
        case (r_state)
            R_IDLE: begin
                valid_nxt = 1'b0;
                last_nxt  = 1'b0;
                if (swap_c) begin
                    act_nxt     = ~act;
                    rd_addr_nxt = '0;
                    r_state_nxt = R_SEND;
                end
            end
            R_SEND: begin
                if (!px_valid) begin
                    rd_en_c   = 1'b1;
                    valid_nxt = 1'b1;
                    last_nxt  = (rd_addr == LAST_ADDR);
                end else if (px_ready) begin
                    valid_nxt = 1'b0;
                    last_nxt  = 1'b0;
                    if (px_last) begin
                        rd_addr_nxt = '0;
                        if (REFRESH_EN) begin
                            r_state_nxt = R_SEND;
                            if (swap_c) begin
                                act_nxt = ~act;
                            end
                        end else begin
                            r_state_nxt = R_IDLE;
                        end
                    end else begin
                        rd_addr_nxt = rd_addr + AW'(1);
                    end
                end
            end
            default: begin
                r_state_nxt = R_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ws2812_frame_buffer.sv
// Directed bench for ws2812_frame_buffer with NUM_LEDS=4; cycle table plus multi-cycle sequences.
// Build with WS2812_FRAME_REFRESH_EN defined to exercise the refresh variant instead.
module tb_ws2812_frame_buffer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_sof;
    logic [23:0] px_data;
    logic        px_valid;
    logic        px_ready;
    logic        px_last;
    logic        frame_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ws2812_frame_buffer #(.NUM_LEDS(4), .AW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_byte   (in_byte),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .px_data   (px_data),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_last   (px_last),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        sof;
        logic [7:0]  b;
        logic        rdy;
        logic        e_pv;
        logic [23:0] e_data;
        logic        e_last;
        logic        e_busy;
        logic        e_err;
    } vec_t;

    vec_t tbl [22];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t stream_row(logic pv, logic [23:0] d, logic l, logic bz);
        vec_t r;
        r = '{1'b0, 1'b0, 8'h00, 1'b1, pv, d, l, bz, 1'b0};
        return r;
    endfunction

    // Drives n consecutive bytes base, base+1, ...; counts frame_err samples including two idle cycles.
    task automatic send_frame(input logic [7:0] base, input int n, input logic sof_first, output int errs);
        errs = 0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_sof   = sof_first && (i == 0);
            in_byte  = base + 8'(i);
            step();
            errs += int'(frame_err);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            errs += int'(frame_err);
        end
    endtask

    task automatic wait_px(input string name, output logic [23:0] d, output logic l);
        int n = 0;
        while (!px_valid && n < 40) begin
            step();
            n++;
        end
        chk({name, " valid"}, 32'(px_valid), 32'd1);
        d = px_data;
        l = px_last;
    endtask

    task automatic recv_px(input string name, input logic [23:0] exp, input logic exp_last);
        logic [23:0] d;
        logic        l;
        wait_px(name, d, l);
        chk({name, " data"}, 32'(d), 32'(exp));
        chk({name, " last"}, 32'(l), 32'(exp_last));
        step();
    endtask

    initial begin
        int          e1, e2, cnt;
        logic [23:0] d;
        logic        l;

        rst_n    = 1'b1;
        in_byte  = 8'h00;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        px_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset px_data", 32'(px_data), 32'd0);
        chk("reset px_valid", 32'(px_valid), 32'd0);
        chk("reset px_last", 32'(px_last), 32'd0);
        chk("reset frame_err", 32'(frame_err), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        step();
        rst_n = 1'b1;
        step();

`ifndef WS2812_FRAME_REFRESH_EN
        // Basic frame, cycle by cycle: 12 bytes in, swap, four pixels at one per two cycles.
        for (int i = 0; i < 12; i++) begin
            tbl[i] = '{1'b1, (i == 0), 8'(i + 1), 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0};
        end
        tbl[12] = stream_row(1'b0, 24'h000000, 1'b0, 1'b1);
        tbl[13] = stream_row(1'b1, 24'h010203, 1'b0, 1'b1);
        tbl[14] = stream_row(1'b0, 24'h000000, 1'b0, 1'b1);
        tbl[15] = stream_row(1'b1, 24'h040506, 1'b0, 1'b1);
        tbl[16] = stream_row(1'b0, 24'h000000, 1'b0, 1'b1);
        tbl[17] = stream_row(1'b1, 24'h070809, 1'b0, 1'b1);
        tbl[18] = stream_row(1'b0, 24'h000000, 1'b0, 1'b1);
        tbl[19] = stream_row(1'b1, 24'h0A0B0C, 1'b1, 1'b1);
        tbl[20] = stream_row(1'b0, 24'h000000, 1'b0, 1'b0);
        tbl[21] = stream_row(1'b0, 24'h000000, 1'b0, 1'b0);

        for (int i = 0; i < 22; i++) begin
            in_valid = tbl[i].v;
            in_sof   = tbl[i].sof;
            in_byte  = tbl[i].b;
            px_ready = tbl[i].rdy;
            step();
            chk($sformatf("row%0d px_valid", i), 32'(px_valid), 32'(tbl[i].e_pv));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("row%0d frame_err", i), 32'(frame_err), 32'(tbl[i].e_err));
            if (tbl[i].e_pv) begin
                chk($sformatf("row%0d px_data", i), 32'(px_data), 32'(tbl[i].e_data));
                chk($sformatf("row%0d px_last", i), 32'(px_last), 32'(tbl[i].e_last));
            end
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;

        // Back-pressure: pixel 1 held for 10 cycles must stay valid and stable.
        px_ready = 1'b0;
        send_frame(8'h21, 12, 1'b1, e1);
        chk("bp frame_err", 32'(e1), 32'd0);
        recv_px("bp px0", 24'h212223, 1'b0);
        px_ready = 1'b1;
        wait_px("bp px0 hold", d, l);
        chk("bp px0 hold data", 32'(d), 32'h212223);
        step();
        px_ready = 1'b0;
        wait_px("bp px1", d, l);
        chk("bp px1 data", 32'(d), 32'h242526);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("bp stall%0d valid", i), 32'(px_valid), 32'd1);
            chk($sformatf("bp stall%0d data", i), 32'(px_data), 32'h242526);
        end
        px_ready = 1'b1;
        recv_px("bp px1 take", 24'h242526, 1'b0);
        recv_px("bp px2", 24'h272829, 1'b0);
        recv_px("bp px3", 24'h2A2B2C, 1'b1);
        chk("bp busy end", 32'(busy), 32'd0);

        // Restart: a new sof inside a partial frame pulses frame_err once.
        send_frame(8'h00, 5, 1'b1, e1);
        send_frame(8'h11, 12, 1'b1, e2);
        chk("restart err pulses", 32'(e1 + e2), 32'd1);
        recv_px("rs px0", 24'h111213, 1'b0);
        recv_px("rs px1", 24'h141516, 1'b0);
        recv_px("rs px2", 24'h171819, 1'b0);
        recv_px("rs px3", 24'h1A1B1C, 1'b1);

        // Overrun: second frame completes while the first stalls, then one extra byte.
        px_ready = 1'b0;
        send_frame(8'h31, 12, 1'b1, e1);
        chk("ov first err", 32'(e1), 32'd0);
        send_frame(8'h41, 12, 1'b1, e1);
        chk("ov second err", 32'(e1), 32'd0);
        send_frame(8'h99, 1, 1'b0, e2);
        chk("ov extra err", 32'(e2), 32'd1);
        px_ready = 1'b1;
        recv_px("ov a0", 24'h313233, 1'b0);
        recv_px("ov a1", 24'h343536, 1'b0);
        recv_px("ov a2", 24'h373839, 1'b0);
        recv_px("ov a3", 24'h3A3B3C, 1'b1);
        recv_px("ov b0", 24'h414243, 1'b0);
        recv_px("ov b1", 24'h444546, 1'b0);
        recv_px("ov b2", 24'h474849, 1'b0);
        recv_px("ov b3", 24'h4A4B4C, 1'b1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cnt += int'(px_valid);
            step();
        end
        chk("ov no third frame", 32'(cnt), 32'd0);
        chk("ov busy idle", 32'(busy), 32'd0);

        // Reset during pixel 2: outputs clear at once, stray bytes ignored afterwards.
        send_frame(8'h51, 12, 1'b1, e1);
        recv_px("rst px0", 24'h515253, 1'b0);
        recv_px("rst px1", 24'h545556, 1'b0);
        wait_px("rst px2", d, l);
        chk("rst px2 data", 32'(d), 32'h575859);
        #2 rst_n = 1'b0;
        #1;
        chk("rst async px_valid", 32'(px_valid), 32'd0);
        chk("rst async px_data", 32'(px_data), 32'd0);
        chk("rst async px_last", 32'(px_last), 32'd0);
        chk("rst async busy", 32'(busy), 32'd0);
        chk("rst async frame_err", 32'(frame_err), 32'd0);
        step();
        rst_n = 1'b1;
        send_frame(8'h05, 3, 1'b0, e1);
        chk("stray err", 32'(e1), 32'd0);
        chk("stray px_valid", 32'(px_valid), 32'd0);
        chk("stray busy", 32'(busy), 32'd0);
        send_frame(8'h61, 12, 1'b1, e1);
        chk("post-rst err", 32'(e1), 32'd0);
        recv_px("post-rst px0", 24'h616263, 1'b0);
        recv_px("post-rst px1", 24'h646566, 1'b0);
        recv_px("post-rst px2", 24'h676869, 1'b0);
        recv_px("post-rst px3", 24'h6A6B6C, 1'b1);
`else
        // Refresh: the committed frame repeats, and a new frame takes over at a frame boundary.
        px_ready = 1'b1;
        send_frame(8'h71, 12, 1'b1, e1);
        chk("rf err", 32'(e1), 32'd0);
        for (int k = 0; k < 2; k++) begin
            recv_px($sformatf("rf%0d px0", k), 24'h717273, 1'b0);
            recv_px($sformatf("rf%0d px1", k), 24'h747576, 1'b0);
            recv_px($sformatf("rf%0d px2", k), 24'h777879, 1'b0);
            recv_px($sformatf("rf%0d px3", k), 24'h7A7B7C, 1'b1);
        end
        send_frame(8'h81, 12, 1'b1, e1);
        chk("rf new err", 32'(e1), 32'd0);
        cnt = 0;
        wait_px("rf seek", d, l);
        while (d != 24'h818283 && cnt < 12) begin
            step();
            wait_px("rf seek", d, l);
            cnt++;
        end
        chk("rf new frame found", 32'(d), 32'h818283);
        recv_px("rf new px0", 24'h818283, 1'b0);
        recv_px("rf new px1", 24'h848586, 1'b0);
        recv_px("rf new px2", 24'h878889, 1'b0);
        recv_px("rf new px3", 24'h8A8B8C, 1'b1);
        recv_px("rf new repeat", 24'h818283, 1'b0);
        chk("rf busy", 32'(busy), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
